// File: rtl/ialu_div_seq.sv
// Sequential radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// Shares the ALU's 33-bit adder: one trial subtraction per cycle, then one sign-fix pass.
module ialu_div_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        exu2div_req_i,
  input  logic [1:0]  exu2div_cmd_i,
  input  logic [31:0] exu2div_op1_i,
  input  logic [31:0] exu2div_op2_i,
  input  logic        exu2div_kill_i,
  output logic        div2exu_busy_o,
  output logic        div2exu_rdy_o,
  output logic [31:0] div2exu_res_o,
  output logic [31:0] div2add_op1_o,
  output logic [31:0] div2add_op2_o,
  output logic        div2add_cmd_o,
  input  logic [31:0] add2div_res_i,
  input  logic [3:0]  add2div_flags_i
);

  typedef enum logic [1:0] {ST_IDLE, ST_CALC, ST_CORR, ST_DONE} state_t;

  state_t      state_q, state_d;
  logic [31:0] d_q, d_d, q_q, q_d, r_q, r_d, res_q, res_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        neg_quo_q, neg_quo_d, neg_rem_q, neg_rem_d, is_rem_q, is_rem_d;
  logic        busy_q, busy_d, rdy_q, rdy_d;

  logic        is_signed, div_zero, div_ovf, trial_ok;
  logic [31:0] op1_mag, op2_mag, trial;
  logic        unused_flags;

  assign is_signed = ~exu2div_cmd_i[0];
  assign op1_mag   = (is_signed & exu2div_op1_i[31]) ? (~exu2div_op1_i + 32'd1) : exu2div_op1_i;
  assign op2_mag   = (is_signed & exu2div_op2_i[31]) ? (~exu2div_op2_i + 32'd1) : exu2div_op2_i;
  assign div_zero  = (exu2div_op2_i == 32'd0);
  assign div_ovf   = is_signed & (exu2div_op1_i == 32'h8000_0000) & (exu2div_op2_i == 32'hFFFF_FFFF);
  assign trial     = {r_q[30:0], q_q[31]};
  // With R[31] set the 33-bit trial is at least 2^32, so it always exceeds D.
  assign trial_ok  = ~add2div_flags_i[3] | r_q[31];
  assign unused_flags = ^add2div_flags_i[2:0];

  always_comb begin
    state_d   = state_q;
    d_d       = d_q;
    q_d       = q_q;
    r_d       = r_q;
    res_d     = res_q;
    cnt_d     = cnt_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    is_rem_d  = is_rem_q;
    div2add_op1_o = 32'd0;
    div2add_op2_o = 32'd0;
    div2add_cmd_o = 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (exu2div_req_i) begin
          is_rem_d  = exu2div_cmd_i[1];
          neg_quo_d = is_signed & (exu2div_op1_i[31] ^ exu2div_op2_i[31]);
          neg_rem_d = is_signed & exu2div_op1_i[31];
          if (div_zero) begin
            res_d   = exu2div_cmd_i[1] ? exu2div_op1_i : 32'hFFFF_FFFF;
            state_d = ST_DONE;
          end else if (div_ovf) begin
            res_d   = exu2div_cmd_i[1] ? 32'd0 : 32'h8000_0000;
            state_d = ST_DONE;
          end else begin
            d_d     = op2_mag;
            q_d     = op1_mag;
            r_d     = 32'd0;
            cnt_d   = 5'd31;
            state_d = ST_CALC;
          end
        end
      end
      ST_CALC: begin
        div2add_op1_o = trial;
        div2add_op2_o = d_q;
        div2add_cmd_o = 1'b0;
        if (trial_ok) begin
          r_d = add2div_res_i;
          q_d = {q_q[30:0], 1'b1};
        end else begin
          r_d = trial;
          q_d = {q_q[30:0], 1'b0};
        end
        cnt_d = cnt_q - 5'd1;
        if (cnt_q == 5'd0) state_d = ST_CORR;
      end
      ST_CORR: begin
        div2add_op2_o = is_rem_q ? r_q : q_q;
        div2add_cmd_o = ~(is_rem_q ? neg_rem_q : neg_quo_q);
        res_d   = add2div_res_i;
        state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase

    // A flush abandons the operation without touching the held result.
    if (exu2div_kill_i) begin
      state_d = ST_IDLE;
      res_d   = res_q;
    end
  end

  assign busy_d = (state_d != ST_IDLE);
  assign rdy_d  = (state_d == ST_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      d_q       <= 32'd0;
      q_q       <= 32'd0;
      r_q       <= 32'd0;
      res_q     <= 32'd0;
      cnt_q     <= 5'd0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      is_rem_q  <= 1'b0;
      busy_q    <= 1'b0;
      rdy_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      d_q       <= d_d;
      q_q       <= q_d;
      r_q       <= r_d;
      res_q     <= res_d;
      cnt_q     <= cnt_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      is_rem_q  <= is_rem_d;
      busy_q    <= busy_d;
      rdy_q     <= rdy_d;
    end
  end

  assign div2exu_busy_o = busy_q;
  assign div2exu_rdy_o  = rdy_q;
  assign div2exu_res_o  = res_q;

endmodule

// File: tb/tb_ialu_div_seq.sv
// Scoreboard bench for ialu_div_seq: a behavioural 33-bit adder and an arithmetic
// reference model feed a queue that an independent monitor drains on each rdy pulse.
module tb_ialu_div_seq;

  localparam logic [1:0] C_DIV = 2'b00, C_DIVU = 2'b01, C_REM = 2'b10, C_REMU = 2'b11;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req, kill;
  logic [1:0]  cmd;
  logic [31:0] op1, op2;
  logic        busy, rdy;
  logic [31:0] res;
  logic [31:0] add_op1, add_op2, add_res;
  logic        add_cmd;
  logic [3:0]  add_flags;
  logic [32:0] sum;

  always #5 clk = ~clk;

  ialu_div_seq dut (
    .clk(clk), .rst_n(rst_n),
    .exu2div_req_i(req), .exu2div_cmd_i(cmd),
    .exu2div_op1_i(op1), .exu2div_op2_i(op2), .exu2div_kill_i(kill),
    .div2exu_busy_o(busy), .div2exu_rdy_o(rdy), .div2exu_res_o(res),
    .div2add_op1_o(add_op1), .div2add_op2_o(add_op2), .div2add_cmd_o(add_cmd),
    .add2div_res_i(add_res), .add2div_flags_i(add_flags)
  );

  // Shared ALU adder: c is bit 32, which is the borrow on subtraction.
  always_comb begin
    sum = add_cmd ? ({1'b0, add_op1} + {1'b0, add_op2}) : ({1'b0, add_op1} - {1'b0, add_op2});
    add_res = sum[31:0];
    add_flags = {sum[32], sum[31:0] == 32'd0, sum[31],
                 (add_cmd ? (add_op1[31] == add_op2[31]) : (add_op1[31] != add_op2[31]))
                 && (sum[31] != add_op1[31])};
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] res;
    int          due;
    string       name;
  } exp_t;

  exp_t        sb_q[$];
  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] last_res = 32'd0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] ref_model(input logic [1:0] c, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, qq, rr;
    if (b == 32'd0) return c[1] ? a : 32'hFFFF_FFFF;
    if (!c[0]) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return c[1] ? 32'd0 : 32'h8000_0000;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      qq = sa / sb;
      rr = sa % sb;
      return c[1] ? rr[31:0] : qq[31:0];
    end
    return c[1] ? (a % b) : (a / b);
  endfunction

  function automatic bit is_special(input logic [1:0] c, input logic [31:0] a, input logic [31:0] b);
    return (b == 32'd0) || (!c[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  // Monitor: every rdy pulse must match the oldest outstanding expectation, value and cycle.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk); #1;
      if (rdy === 1'b1) begin
        if (sb_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_rdy: got rdy=1 with res %h, required no result (cycle %0d)", res, cyc);
        end else begin
          e = sb_q.pop_front();
          check(e.name, res, e.res);
          check({e.name, "_cycle"}, 32'(cyc), 32'(e.due));
        end
      end
    end
  end

  // Called at posedge+1; waits for idle (optionally scribbling on inputs while busy), then issues.
  task automatic issue(input string nm, input logic [1:0] c, input logic [31:0] a,
                       input logic [31:0] b, input bit expect_done, input bit junk);
    int guard = 0;
    exp_t e;
    while (busy !== 1'b0) begin
      if (junk) begin
        req = 1'($urandom_range(0, 1));
        cmd = 2'($urandom);
        op1 = $urandom;
        op2 = $urandom;
      end
      @(posedge clk); #1;
      guard++;
      if (guard > 100) begin
        $display("FAIL %s_idle_timeout: busy stuck high, required low within 100 cycles", nm);
        $fatal(1, "timeout");
      end
    end
    req = 1'b1;
    cmd = c;
    op1 = a;
    op2 = b;
    if (expect_done) begin
      e.res  = ref_model(c, a, b);
      e.due  = cyc + (is_special(c, a, b) ? 1 : 34);
      e.name = nm;
      sb_q.push_back(e);
      last_res = e.res;
    end
    @(posedge clk); #1;
    req = 1'b0;
    cmd = 2'($urandom);
    op1 = $urandom;
    op2 = $urandom;
  endtask

  task automatic drain();
    int guard = 0;
    while (sb_q.size() != 0 && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    if (sb_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain_timeout: %0d results outstanding, required 0", sb_q.size());
      sb_q.delete();
    end
    while (busy === 1'b1 && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
  endtask

  task automatic check_reset_outputs(input string nm);
    check({nm, "_busy"}, {31'd0, busy}, 32'd0);
    check({nm, "_rdy"}, {31'd0, rdy}, 32'd0);
    check({nm, "_res"}, res, 32'd0);
    check({nm, "_aop1"}, add_op1, 32'd0);
    check({nm, "_aop2"}, add_op2, 32'd0);
    check({nm, "_acmd"}, {31'd0, add_cmd}, 32'd1);
  endtask

  typedef struct {
    string       name;
    logic [1:0]  c;
    logic [31:0] a;
    logic [31:0] b;
  } vec_t;

  vec_t dir_vecs[$];

  initial begin
    rst_n = 1'b0;
    req = 1'b0; kill = 1'b0; cmd = 2'b00; op1 = 32'd0; op2 = 32'd0;
    #1;
    check_reset_outputs("reset_init");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    dir_vecs.push_back('{"divu_100_7",   C_DIVU, 32'd100, 32'd7});
    dir_vecs.push_back('{"remu_100_7",   C_REMU, 32'd100, 32'd7});
    dir_vecs.push_back('{"div_m7_2",     C_DIV,  32'hFFFF_FFF9, 32'd2});
    dir_vecs.push_back('{"rem_m7_2",     C_REM,  32'hFFFF_FFF9, 32'd2});
    dir_vecs.push_back('{"div_7_m2",     C_DIV,  32'd7, 32'hFFFF_FFFE});
    dir_vecs.push_back('{"rem_7_m2",     C_REM,  32'd7, 32'hFFFF_FFFE});
    dir_vecs.push_back('{"divu_5_0",     C_DIVU, 32'd5, 32'd0});
    dir_vecs.push_back('{"rem_5_0",      C_REM,  32'd5, 32'd0});
    dir_vecs.push_back('{"div_ovf",      C_DIV,  32'h8000_0000, 32'hFFFF_FFFF});
    dir_vecs.push_back('{"rem_ovf",      C_REM,  32'h8000_0000, 32'hFFFF_FFFF});
    dir_vecs.push_back('{"remu_r31",     C_REMU, 32'hFFFF_FFFF, 32'h8000_0001});
    dir_vecs.push_back('{"divu_max_1",   C_DIVU, 32'hFFFF_FFFF, 32'd1});
    dir_vecs.push_back('{"divu_max_max", C_DIVU, 32'hFFFF_FFFF, 32'hFFFF_FFFF});
    foreach (dir_vecs[i]) issue(dir_vecs[i].name, dir_vecs[i].c, dir_vecs[i].a, dir_vecs[i].b, 1'b1, 1'b0);
    drain();

    // Kill in the 10th CALC cycle, then restart immediately.
    issue("killed", C_DIVU, 32'h1234_5678, 32'd3, 1'b0, 1'b0);
    repeat (9) @(posedge clk);
    #1;
    kill = 1'b1;
    @(posedge clk); #1;
    kill = 1'b0;
    check("kill_busy", {31'd0, busy}, 32'd0);
    check("kill_res_held", res, last_res);
    issue("divu_9_3_after_kill", C_DIVU, 32'd9, 32'd3, 1'b1, 1'b0);
    drain();

    // Kill together with a request in IDLE: request dropped.
    req = 1'b1; kill = 1'b1; cmd = C_DIVU; op1 = 32'd50; op2 = 32'd5;
    @(posedge clk); #1;
    req = 1'b0; kill = 1'b0;
    check("kill_req_idle_busy", {31'd0, busy}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check("kill_req_idle_res", res, last_res);

    // Asynchronous reset in the middle of CALC.
    issue("reset_victim", C_DIVU, 32'd1000, 32'd7, 1'b0, 1'b0);
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("reset_mid");
    last_res = 32'd0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_reset_outputs("reset_after");
    issue("divu_after_reset", C_DIVU, 32'd1000, 32'd7, 1'b1, 1'b0);
    drain();

    // Randomized mix, scribbling on the inputs while the divider is busy.
    for (int n = 0; n < 40; n++) begin
      logic [1:0]  c;
      logic [31:0] a, b;
      c = 2'($urandom);
      a = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = 32'($urandom_range(1, 20));
        3: b = $urandom | 32'h8000_0000;
        4: b = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
        default: b = $urandom;
      endcase
      issue($sformatf("rand%0d", n), c, a, b, 1'b1, 1'b1);
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ialu_div_seq.md
# ialu_div_seq

Sequential radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU in the integer ALU. It sits beside the main 33-bit adder and time-shares it, driving its operands and command each cycle and consuming its 32-bit result and carry flag. It takes one trial subtraction per cycle, then one sign-correction pass through the same adder. It accepts a request from EXU while idle and returns one 32-bit result after a fixed latency.

## Interface
- No parameters; data width fixed at 32.
- clk  in  1  core clock
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- exu2div_req_i  in  1  start request, sampled only when div2exu_busy_o=0
- exu2div_cmd_i  in  2  00 DIV, 01 DIVU, 10 REM, 11 REMU
- exu2div_op1_i  in  32  dividend
- exu2div_op2_i  in  32  divisor
- exu2div_kill_i  in  1  abort current operation (pipeline flush)
- div2exu_busy_o  out  1  operation in flight
- div2exu_rdy_o  out  1  one-cycle result-valid pulse
- div2exu_res_o  out  32  result; held until next completion
- div2add_op1_o  out  32  adder operand 1
- div2add_op2_o  out  32  adder operand 2
- div2add_cmd_o  out  1  1 = add, 0 = subtract
- add2div_res_i  in  32  adder result [31:0]
- add2div_flags_i  in  4  {c,z,s,o}; c = bit 32 of the 33-bit result, 1 = borrow on subtract

## Operation
- States: IDLE, CALC, CORR, DONE.
- IDLE + req (no kill), normal case:
  - latch divisor magnitude D, using internal two's-complement negation for signed cmds.
  - Q = dividend magnitude, R = 0, cnt = 31.
  - latch neg_q = signed & (op1[31]^op2[31]) and neg_r = signed & op1[31].
  - go to CALC.
- Special cases, IDLE→DONE directly with the result loaded:
  - op2 = 0: DIV/DIVU → 0xFFFFFFFF; REM/REMU → op1.
  - Signed op1 = 0x80000000, op2 = 0xFFFFFFFF: DIV → 0x80000000; REM → 0.
- CALC, each cycle:
  - trial = {R[30:0], Q[31]}; op1_o = trial, op2_o = D, cmd_o = 0.
  - Success = (c==0) | R[31]. When R[31]=1 the 33-bit trial exceeds D, and the low 32 bits of the difference are exact.
  - Success: R ← add2div_res_i, Q ← {Q[30:0],1}.
  - Failure: R ← trial, Q ← {Q[30:0],0}.
  - cnt decrements; cnt = 0 → CORR.
- CORR:
  - op1_o = 0; op2_o = Q for DIV/DIVU, R for REM/REMU.
  - cmd_o = 0 if the selected neg flag is set (negate), else 1 (pass through).
  - res_o ← add2div_res_i; go to DONE.
- DONE: rdy_o = 1 for this cycle; go to IDLE.
- Idle adder drive: op1_o = 0, op2_o = 0, cmd_o = 1.
- kill:
  - Any state → IDLE on next edge. No rdy pulse; res_o unchanged.
  - kill with req in IDLE: kill wins, request dropped.
  - kill in DONE: rdy_o still high in that cycle, because it is registered.
- Reset: state IDLE. busy_o, rdy_o, res_o, op1_o, op2_o = 0; cmd_o = 1. Any in-flight operation is discarded.

## Timing
- Request sampled in cycle N.
- Normal operation: CALC in N+1..N+32, CORR in N+33, rdy_o = 1 in N+34.
- busy_o high N+1..N+34. Next request accepted in N+35 at earliest.
- Special case: DONE in N+1, rdy_o and busy_o high in N+1 only.
- Adder path is combinational within each cycle. Outputs to the adder are state-decoded; add2div_res_i and flags are registered at the end of the same cycle.
- rdy_o, res_o, busy_o are registered outputs.
- Operands and cmd are captured at accept; later changes on exu2div_* are ignored while busy.

## Test plan
- DIVU 100/7: req at N → rdy at N+34, res = 14. REMU same operands → 2.
- Signed ops:
  - DIV -7/2 → 0xFFFFFFFD; REM -7/2 → 0xFFFFFFFF.
  - DIV 7/-2 → 0xFFFFFFFD; REM 7/-2 → 1.
- Special cases, each rdy at N+1:
  - DIVU 5/0 → 0xFFFFFFFF; REM 5/0 → 5.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM same → 0.
- R[31] path:
  - REMU 0xFFFFFFFF/0x80000001 → 0x7FFFFFFE.
  - DIVU 0xFFFFFFFF/1 → 0xFFFFFFFF.
  - DIVU 0xFFFFFFFF/0xFFFFFFFF → 1.
- Kill and restart: kill in 10th CALC cycle → busy_o low next cycle, no rdy, res_o keeps its old value. A new DIVU 9/3 issued the cycle after completes 34 cycles later with 3.
- Reset: rst_n asserted mid-CALC → all outputs reset immediately (asynchronous). After release, a fresh request completes with full latency.
